timebase_sched: RTL

Central timebase and repeat scheduler for the clock-calendar datapath. It replaces the free-running per-rate square-wave dividers with one cascaded prescaler, and emits single-cycle enable strobes in the CLK_50M domain. It also adds a run/pause gate and a second-phase resync for timekeeping, plus a key auto-repeat scheduler that paces ADV pulses for the time-set logic.

---
 rtl/timebase_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/timebase_sched.sv
// -----------------------------------------------------------------------------
// timebase_sched
//
// Central timebase and key auto-repeat scheduler for the clock-calendar
// datapath. A single cascaded prescaler derives a 1 ms wrap from CLK_50M.
// All rate strobes are built from that wrap, so every strobe is a
// single-cycle enable in the CLK_50M domain rather than a divided clock.
//
// Parameters
//   CLK_FREQ    input clock frequency in Hz (multiple of 1000, >= 2000)
//   HOLD_MS     ms a key must be held before auto-repeat starts (1..1023)
//   SLOW_MS     slow repeat period in ms (1..1023)
//   FAST_MS     fast repeat period in ms (1..1023)
//   FAST_AFTER  slow repeats before switching to fast (1..15)
//
// Ports
//   CLK_50M    in   system clock
//   nCLR       in   asynchronous active-low reset
//   RUN        in   1 = ms counter advances (gates TICK_4/TICK_2/TICK_1)
//   SYNC       in   one-cycle pulse; restarts the sub-second phase
//   KEY        in   debounced synchronous key level
//   TICK_1K    out  1 kHz strobe
//   TICK_500   out  500 Hz strobe
//   TICK_4     out  4 Hz strobe (RUN-gated)
//   TICK_2     out  2 Hz strobe (RUN-gated)
//   TICK_1     out  1 Hz strobe (RUN-gated)
//   ADV        out  one-cycle advance pulse for the time-set logic
//   REP_STATE  out  repeat FSM state: 00 IDLE, 01 DELAY, 10 SLOW, 11 FAST
// -----------------------------------------------------------------------------
module timebase_sched #(
    parameter int CLK_FREQ   = 50000000,
    parameter int HOLD_MS    = 500,
    parameter int SLOW_MS    = 250,
    parameter int FAST_MS    = 50,
    parameter int FAST_AFTER = 4
) (
    input  logic       CLK_50M,
    input  logic       nCLR,
    input  logic       RUN,
    input  logic       SYNC,
    input  logic       KEY,
    output logic       TICK_1K,
    output logic       TICK_500,
    output logic       TICK_4,
    output logic       TICK_2,
    output logic       TICK_1,
    output logic       ADV,
    output logic [1:0] REP_STATE
);

    localparam int DIV = CLK_FREQ / 1000;
    localparam int PW  = $clog2(DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [9:0]    HOLD_LAST  = 10'(HOLD_MS - 1);
    localparam logic [9:0]    SLOW_LAST  = 10'(SLOW_MS - 1);
    localparam logic [9:0]    FAST_LAST  = 10'(FAST_MS - 1);
    localparam logic [3:0]    FAST_CNT   = 4'(FAST_AFTER);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        SLOW  = 2'b10,
        FAST  = 2'b11
    } rep_state_t;

    logic [PW-1:0] presc;
    logic          p500;
    logic [9:0]    ms;
    logic          wrap;
    logic          tick;
    logic          ms_step;

    rep_state_t    state;
    logic [9:0]    timer;
    logic [3:0]    rep_cnt;
    logic          key_d;

    assign wrap    = (presc == PRESC_LAST);
    // A SYNC coinciding with a wrap swallows that wrap everywhere, so the
    // restarted phase never emits a strobe for the abandoned millisecond.
    assign tick    = wrap & ~SYNC;
    assign ms_step = tick & RUN;

    // -------------------------------------------------------------------------
    // Prescaler, 500 Hz phase, ms counter and rate strobes
    // -------------------------------------------------------------------------
    // NOTE: asynchronous active-low reset lives in the sensitivity list so the
    // outputs clear the moment nCLR falls, without waiting for a clock edge.
    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            presc    <= '0;
            p500     <= 1'b0;
            ms       <= '0;
            TICK_1K  <= 1'b0;
            TICK_500 <= 1'b0;
            TICK_4   <= 1'b0;
            TICK_2   <= 1'b0;
            TICK_1   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in clocked logic, so
            // every strobe below sees the pre-edge values of presc/p500/ms.
            if (SYNC) begin
                presc <= '0;
                p500  <= 1'b0;
                ms    <= '0;
            end else if (wrap) begin
                presc <= '0;
                p500  <= ~p500;
                if (RUN) begin
                    ms <= (ms == 10'd999) ? 10'd0 : ms + 10'd1;
                end
            end else begin
                presc <= presc + 1'b1;
            end

            TICK_1K  <= tick;
            TICK_500 <= tick & p500;
            TICK_4   <= ms_step & ((ms == 10'd249) || (ms == 10'd499) ||
                                   (ms == 10'd749) || (ms == 10'd999));
            TICK_2   <= ms_step & ((ms == 10'd499) || (ms == 10'd999));
            TICK_1   <= ms_step & (ms == 10'd999);
        end
    end

    // -------------------------------------------------------------------------
    // Key auto-repeat scheduler. The timer counts prescaler wraps, not the
    // RUN-gated ms counter, so repeat pacing continues while time is paused.
    // key_d resets to 1: a key held through reset must be released first.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            state   <= IDLE;
            timer   <= '0;
            rep_cnt <= '0;
            key_d   <= 1'b1;
            ADV     <= 1'b0;
        end else begin
            key_d <= KEY;
            ADV   <= 1'b0;
            // Release beats any coincident timer expiry.
            if (!KEY) begin
                state   <= IDLE;
                timer   <= '0;
                rep_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!key_d) begin
                            ADV   <= 1'b1;
                            state <= DELAY;
                            timer <= '0;
                        end
                    end
                    DELAY: begin
                        if (tick) begin
                            if (timer == HOLD_LAST) begin
                                ADV     <= 1'b1;
                                state   <= SLOW;
                                timer   <= '0;
                                rep_cnt <= 4'd1;
                            end else begin
                                timer <= timer + 10'd1;
                            end
                        end
                    end
                    SLOW: begin
                        if (tick) begin
                            if (timer == SLOW_LAST) begin
                                ADV     <= 1'b1;
                                timer   <= '0;
                                rep_cnt <= rep_cnt + 4'd1;
                                if ((rep_cnt + 4'd1) >= FAST_CNT) begin
                                    state <= FAST;
                                end
                            end else begin
                                timer <= timer + 10'd1;
                            end
                        end
                    end
                    FAST: begin
                        if (tick) begin
                            if (timer == FAST_LAST) begin
                                ADV   <= 1'b1;
                                timer <= '0;
                            end else begin
                                timer <= timer + 10'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign REP_STATE = state;

endmodule
